// File: rtl/mmss_timer.sv
// MM:SS BCD up/down timer with preset load, pause/resume, expiry flag and an internal 1 Hz divider.
// Optional macro MMSS_TIMER_AUTORELOAD_EN: reload the latched preset instead of expiring.
module mmss_timer #(
    parameter int CLK_HZ      = 50000000,
    parameter int DIV_W       = 26,
    parameter int MAX_MINUTES = 59
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic       stop,
    input  logic       load,
    input  logic       count_up,
    input  logic [3:0] pre_mt,
    input  logic [3:0] pre_mo,
    input  logic [3:0] pre_st,
    input  logic [3:0] pre_so,
    output logic [3:0] mt,
    output logic [3:0] mo,
    output logic [3:0] st,
    output logic [3:0] so,
    output logic       running,
    output logic       expired,
    output logic       done,
    output logic       tick,
    output logic       load_err
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_HZ - 1);
    localparam logic [15:0] ZERO_VAL = 16'h0000;
    localparam logic [15:0] MAX_VAL  = {4'(MAX_MINUTES / 10), 4'(MAX_MINUTES % 10), 4'd5, 4'd9};

    state_t           state, state_nx;
    logic [15:0]      val, val_nx, preset, preset_nx;
    logic [15:0]      pre_val, step_val, term_val;
    logic [DIV_W-1:0] div, div_nx;
    logic [7:0]       pre_min;
    logic             dir, dir_nx;
    logic             done_nx, tick_nx, load_err_nx;
    logic             pre_ok, start_blk;

    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [3:0] m_t, m_o, s_t, s_o;
        {m_t, m_o, s_t, s_o} = v;
        if (s_o != 4'd0) s_o = s_o - 4'd1;
        else begin
            s_o = 4'd9;
            if (s_t != 4'd0) s_t = s_t - 4'd1;
            else begin
                s_t = 4'd5;
                if (m_o != 4'd0) m_o = m_o - 4'd1;
                else begin
                    m_o = 4'd9;
                    m_t = m_t - 4'd1;
                end
            end
        end
        return {m_t, m_o, s_t, s_o};
    endfunction

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [3:0] m_t, m_o, s_t, s_o;
        {m_t, m_o, s_t, s_o} = v;
        if (s_o != 4'd9) s_o = s_o + 4'd1;
        else begin
            s_o = 4'd0;
            if (s_t != 4'd5) s_t = s_t + 4'd1;
            else begin
                s_t = 4'd0;
                if (m_o != 4'd9) m_o = m_o + 4'd1;
                else begin
                    m_o = 4'd0;
                    m_t = m_t + 4'd1;
                end
            end
        end
        return {m_t, m_o, s_t, s_o};
    endfunction

    assign pre_val = {pre_mt, pre_mo, pre_st, pre_so};
    assign pre_min = 8'(pre_mt) * 8'd10 + 8'(pre_mo);
    assign pre_ok  = (pre_mt <= 4'd9) && (pre_mo <= 4'd9) && (pre_st <= 4'd5) &&
                     (pre_so <= 4'd9) && (pre_min <= 8'(MAX_MINUTES));

`ifdef MMSS_TIMER_AUTORELOAD_EN
    assign start_blk = 1'b0;
`else
    // Starting from the terminal value of the requested direction would expire immediately.
    assign start_blk = (val == (count_up ? MAX_VAL : ZERO_VAL));
`endif

    always_comb begin
        state_nx    = state;
        val_nx      = val;
        preset_nx   = preset;
        div_nx      = div;
        dir_nx      = dir;
        done_nx     = 1'b0;
        tick_nx     = 1'b0;
        load_err_nx = 1'b0;
        term_val    = dir ? MAX_VAL : ZERO_VAL;
        step_val    = dir ? bcd_inc(val) : bcd_dec(val);

        if (load) begin
            if (pre_ok) begin
                val_nx    = pre_val;
                preset_nx = pre_val;
                div_nx    = '0;
                state_nx  = IDLE;
            end else begin
                load_err_nx = 1'b1;
            end
        end else begin
            case (state)
                RUN: begin
                    if (stop) state_nx = PAUSED;
                    if (div == DIV_LAST) begin
                        div_nx  = '0;
                        tick_nx = 1'b1;
`ifdef MMSS_TIMER_AUTORELOAD_EN
                        val_nx  = (val == term_val) ? preset : step_val;
                        done_nx = (val_nx == term_val);
`else
                        val_nx  = step_val;
                        done_nx = (val_nx == term_val);
                        if (done_nx) state_nx = EXPIRED;
`endif
                    end else begin
                        div_nx = div + 1'b1;
                    end
                end
                IDLE, PAUSED: begin
                    if (start && !stop && !start_blk) begin
                        state_nx = RUN;
                        dir_nx   = count_up;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            val      <= '0;
            preset   <= '0;
            div      <= '0;
            dir      <= 1'b0;
            running  <= 1'b0;
            expired  <= 1'b0;
            done     <= 1'b0;
            tick     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            state    <= state_nx;
            val      <= val_nx;
            preset   <= preset_nx;
            div      <= div_nx;
            dir      <= dir_nx;
            running  <= (state_nx == RUN);
            expired  <= (state_nx == EXPIRED);
            done     <= done_nx;
            tick     <= tick_nx;
            load_err <= load_err_nx;
        end
    end

    assign {mt, mo, st, so} = val;

endmodule

// File: tb/tb_mmss_timer.sv
// Directed bench for mmss_timer with CLK_HZ=4, MAX_MINUTES=1; define MMSS_TIMER_AUTORELOAD_EN for reload mode.
module tb_mmss_timer;
    logic       clock, reset_n, start, stop, load, count_up;
    logic [3:0] pre_mt, pre_mo, pre_st, pre_so;
    logic [3:0] mt, mo, st, so;
    logic       running, expired, done, tick, load_err;
    logic [15:0] v;
    int checks = 0;
    int errors = 0;

    mmss_timer #(.CLK_HZ(4), .DIV_W(3), .MAX_MINUTES(1)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .stop(stop), .load(load),
        .count_up(count_up), .pre_mt(pre_mt), .pre_mo(pre_mo), .pre_st(pre_st), .pre_so(pre_so),
        .mt(mt), .mo(mo), .st(st), .so(so), .running(running), .expired(expired),
        .done(done), .tick(tick), .load_err(load_err)
    );

    assign v = {mt, mo, st, so};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_load(input logic [15:0] p);
        {pre_mt, pre_mo, pre_st, pre_so} = p;
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic do_start(input logic dir);
        count_up = dir;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) step();
        checks++;
        if (v !== 16'h0000) begin errors++; $display("FAIL reset_digits got %h want 0000", v); end
        checks++;
        if ({running, expired, done, tick, load_err} !== 5'b0) begin
            errors++; $display("FAIL reset_flags got %b want 00000", {running, expired, done, tick, load_err});
        end
        #3 reset_n = 1'b1;
        step();
    endtask

    task automatic test_down_expire();
        logic [15:0] exp_v [3];
        exp_v[0] = 16'h0002; exp_v[1] = 16'h0001; exp_v[2] = 16'h0000;
        do_load(16'h0003);
        checks++;
        if (v !== 16'h0003) begin errors++; $display("FAIL down_load got %h want 0003", v); end
        do_start(1'b0);
        checks++;
        if (running !== 1'b1) begin errors++; $display("FAIL down_running got %b want 1", running); end
        for (int k = 0; k < 3; k++) begin
            repeat (3) step();
            checks++;
            if (tick !== 1'b0) begin errors++; $display("FAIL down_early_tick%0d got %b want 0", k, tick); end
            step();
            checks++;
            if ({v, tick} !== {exp_v[k], 1'b1}) begin
                errors++; $display("FAIL down_tick%0d got %h/%b want %h/1", k, v, tick, exp_v[k]);
            end
            checks++;
            if (done !== (k == 2)) begin errors++; $display("FAIL down_done%0d got %b want %b", k, done, k == 2); end
        end
        checks++;
        if ({expired, running} !== 2'b10) begin
            errors++; $display("FAIL down_expired got %b want 10", {expired, running});
        end
        step();
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL down_done_pulse got %b want 0", done); end
        do_start(1'b1);
        step();
        checks++;
        if ({v, expired, running} !== {16'h0000, 2'b10}) begin
            errors++; $display("FAIL down_start_in_expired got %h/%b want 0000/10", v, {expired, running});
        end
    endtask

    task automatic test_up_saturate();
        do_load(16'h0158);
        do_start(1'b1);
        repeat (4) step();
        checks++;
        if ({v, done, expired, running} !== {16'h0159, 3'b110}) begin
            errors++; $display("FAIL up_terminal got %h/%b want 0159/110", v, {done, expired, running});
        end
        repeat (8) step();
        checks++;
        if ({v, done, tick, expired} !== {16'h0159, 3'b001}) begin
            errors++; $display("FAIL up_hold got %h/%b want 0159/001", v, {done, tick, expired});
        end
    endtask

    task automatic test_pause();
        int seen;
        seen = 0;
        do_load(16'h0005);
        do_start(1'b0);
        step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        checks++;
        if (running !== 1'b0) begin errors++; $display("FAIL pause_running got %b want 0", running); end
        repeat (10) begin
            step();
            if (tick) seen = 1;
        end
        checks++;
        if ({v, running, seen[0]} !== {16'h0005, 2'b00}) begin
            errors++; $display("FAIL pause_hold got %h/%b/%0d want 0005/0/0", v, running, seen);
        end
        do_start(1'b0);
        checks++;
        if (running !== 1'b1) begin errors++; $display("FAIL resume_running got %b want 1", running); end
        step();
        checks++;
        if (tick !== 1'b0) begin errors++; $display("FAIL resume_early_tick got %b want 0", tick); end
        step();
        checks++;
        if ({v, tick} !== {16'h0004, 1'b1}) begin
            errors++; $display("FAIL resume_tick got %h/%b want 0004/1", v, tick);
        end
    endtask

    task automatic test_load_err();
        do_load(16'h0070);
        checks++;
        if ({load_err, v, running} !== {1'b1, 16'h0004, 1'b1}) begin
            errors++; $display("FAIL load_err_st got %b/%h/%b want 1/0004/1", load_err, v, running);
        end
        do_load(16'h0200);
        checks++;
        if ({load_err, v, running} !== {1'b1, 16'h0004, 1'b1}) begin
            errors++; $display("FAIL load_err_min got %b/%h/%b want 1/0004/1", load_err, v, running);
        end
        do_load(16'h000A);
        checks++;
        if (load_err !== 1'b1) begin errors++; $display("FAIL load_err_so got %b want 1", load_err); end
        do_load(16'h0000);
        checks++;
        if ({load_err, v, running} !== {1'b0, 16'h0000, 1'b0}) begin
            errors++; $display("FAIL load_ok got %b/%h/%b want 0/0000/0", load_err, v, running);
        end
`ifndef MMSS_TIMER_AUTORELOAD_EN
        do_start(1'b0);
        checks++;
        if (running !== 1'b0) begin errors++; $display("FAIL start_zero_down got %b want 0", running); end
`endif
        do_start(1'b1);
        checks++;
        if (running !== 1'b1) begin errors++; $display("FAIL start_zero_up got %b want 1", running); end
    endtask

    task automatic test_async_reset();
        do_load(16'h0105);
        do_start(1'b0);
        repeat (2) step();
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({v, running, expired, done, tick, load_err} !== 21'h0) begin
            errors++; $display("FAIL async_reset got %h/%b want 0000/00000", v, {running, expired, done, tick, load_err});
        end
        step();
        #3 reset_n = 1'b1;
        step();
        checks++;
        if ({v, running} !== 17'h0) begin errors++; $display("FAIL reset_release got %h/%b want 0000/0", v, running); end
        do_start(1'b1);
        checks++;
        if (running !== 1'b1) begin errors++; $display("FAIL idle_after_reset got %b want 1", running); end
    endtask

`ifdef MMSS_TIMER_AUTORELOAD_EN
    task automatic test_autoreload();
        logic [15:0] exp_v [4];
        logic        exp_d [4];
        exp_v[0] = 16'h0001; exp_v[1] = 16'h0000; exp_v[2] = 16'h0002; exp_v[3] = 16'h0001;
        exp_d[0] = 1'b0; exp_d[1] = 1'b1; exp_d[2] = 1'b0; exp_d[3] = 1'b0;
        do_load(16'h0002);
        do_start(1'b0);
        for (int k = 0; k < 4; k++) begin
            repeat (4) step();
            checks++;
            if ({v, done, expired, running} !== {exp_v[k], exp_d[k], 2'b01}) begin
                errors++; $display("FAIL reload%0d got %h/%b want %h/%b01", k, v, {done, expired, running}, exp_v[k], exp_d[k]);
            end
        end
    endtask
`endif

    initial begin
        reset_n = 1'b0; start = 1'b0; stop = 1'b0; load = 1'b0; count_up = 1'b0;
        pre_mt = '0; pre_mo = '0; pre_st = '0; pre_so = '0;
        test_reset();
`ifdef MMSS_TIMER_AUTORELOAD_EN
        test_autoreload();
`else
        test_down_expire();
        test_up_saturate();
`endif
        test_pause();
        test_load_err();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
